// File: rtl/seg_scan_scheduler_pkg.sv
// Shared types and constants for the seven-segment display blocks.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_e;

   // All segments dark (active-low bus).
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Hex to active-low {g,f,e,d,c,b,a}; entry 15 first. b and d use lowercase shapes.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// Load handshake between a result producer and the scan scheduler.
interface seg_scan_scheduler_if;
   logic        LOAD_VALID;
   logic        LOAD_READY;
   logic [15:0] LOAD_DATA;
   logic [3:0]  LOAD_DP;

   modport master (output LOAD_VALID, output LOAD_DATA, output LOAD_DP, input LOAD_READY);
   modport slave  (input LOAD_VALID, input LOAD_DATA, input LOAD_DP, output LOAD_READY);
endinterface

// File: rtl/seg_scan_scheduler_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg_scan_scheduler.sv
// Four-digit common-anode scan controller: blanked guard at the start of each
// digit slot, double-buffered value swapped only at frame boundaries.
module seg_scan_scheduler
   import seg_pkg::*;
#(
   parameter int TICK_DIV = 50000,
   parameter int GUARD    = 4
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   seg_scan_scheduler_if.slave  load,
   input  logic                 LZ_EN,
   output logic [3:0]           AN,
   output logic [6:0]           CA,
   output logic                 DP,
   output logic                 FRAME_DONE
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PCNT_LAST  = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD - 1);

   state_e         state_q, state_d;
   logic [PW-1:0]  pcnt_q, pcnt_d;
   logic [1:0]     dig_q, dig_d;
   logic [3:0]     an_q, an_d;
   logic [6:0]     ca_q, ca_d;
   logic           dp_q, dp_d;
   logic           fd_q, fd_d;

   logic [15:0]    pend_data_q;
   logic [3:0]     pend_dp_q;
   logic           pend_full_q;
   logic [15:0]    disp_data_q;
   logic [3:0]     disp_dp_q;

   logic           slot_end, frame_end, accept;
   logic [3:0][6:0] dig_seg;
   logic [3:0]     lz_sup;

   assign slot_end  = (state_q != IDLE) && (pcnt_q == PCNT_LAST);
   assign frame_end = slot_end && (dig_q == 2'd3);
   assign accept    = load.LOAD_VALID && !pend_full_q;

   assign load.LOAD_READY = ~pend_full_q;

   // One decoder per digit; digit k is suppressed when it and all higher nibbles are zero.
   for (genvar g = 0; g < 4; g++) begin : g_dig
      hex7seg u_hex (
         .hex_i (disp_data_q[4*g +: 4]),
         .seg_o (dig_seg[g])
      );
      if (g == 0) begin : g_lsd
         assign lz_sup[g] = 1'b0;
      end else begin : g_msd
         assign lz_sup[g] = LZ_EN && ~|disp_data_q[15:4*g];
      end
   end

   // Next state: prescaler, digit rotation, guard/drive phases and output values.
   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      dig_d   = dig_q;
      an_d    = 4'hF;
      ca_d    = SEG_BLANK;
      dp_d    = 1'b1;
      fd_d    = frame_end;

      if (slot_end) begin
         pcnt_d = '0;
         dig_d  = dig_q + 2'd1;
      end else begin
         pcnt_d = pcnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            state_d = BLANK;
            pcnt_d  = '0;
            dig_d   = 2'd0;
         end
         BLANK: begin
            if (slot_end)                  state_d = BLANK;
            else if (pcnt_q == GUARD_LAST) state_d = DRIVE;
         end
         DRIVE: begin
            if (!lz_sup[dig_q]) begin
               an_d = ~(4'b0001 << dig_q);
               ca_d = dig_seg[dig_q];
               dp_d = ~disp_dp_q[dig_q];
            end
            if (slot_end) state_d = BLANK;
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan FSM with registered pin outputs.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         pcnt_q  <= '0;
         dig_q   <= 2'd0;
         an_q    <= 4'hF;
         ca_q    <= SEG_BLANK;
         dp_q    <= 1'b1;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         dig_q   <= dig_d;
         an_q    <= an_d;
         ca_q    <= ca_d;
         dp_q    <= dp_d;
         fd_q    <= fd_d;
      end
   end

   // Pending/display buffers; a load arriving on a frame edge waits a full frame.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         pend_data_q <= '0;
         pend_dp_q   <= '0;
         pend_full_q <= 1'b0;
         disp_data_q <= '0;
         disp_dp_q   <= '0;
      end else begin
         if (accept) begin
            pend_data_q <= load.LOAD_DATA;
            pend_dp_q   <= load.LOAD_DP;
            pend_full_q <= 1'b1;
         end else if (frame_end && pend_full_q) begin
            pend_full_q <= 1'b0;
         end
         if (frame_end && pend_full_q) begin
            disp_data_q <= pend_data_q;
            disp_dp_q   <= pend_dp_q;
         end
      end
   end

   assign AN         = an_q;
   assign CA         = ca_q;
   assign DP         = dp_q;
   assign FRAME_DONE = fd_q;

endmodule
